// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned HzStW = 2;

    typedef enum logic [HzStW-1:0] {
        StRun      = 2'd0,
        StLuBubble = 2'd1,
        StMdBusy   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module hz_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Count up on inc until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: per-stage enables and bubbles,
// mul/div occupancy tracking, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_ex_hazard,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned MdW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    // Busy window spans MD_LAT cycles: count MD_LAT-1 down to 0.
    localparam logic [MdW-1:0] MdLoad = MdW'(MD_LAT - 1);

    hz_state_e      state_q, state_d;
    logic [MdW-1:0] md_cnt_q, md_cnt_d;
    logic           mem_wait;
    logic           stall_inc, flush_inc;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign md_busy  = (state_q == StMdBusy);

    // Stage controls and next state; reset forces all enables off and all bubbles on.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        flush_inc   = 1'b0;
        if (rst_n) begin
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
            // The mul/div unit keeps counting even while memory stalls the pipe.
            if (state_q == StMdBusy) begin
                if (md_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    md_cnt_d = md_cnt_q - MdW'(1);
                end
            end
            if (mem_wait) begin
                // Freeze everything; enables already low, no bubbles.
            end else if (state_q == StMdBusy ||
                         (state_q == StRun && mem_ex_hazard)) begin
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                exmem_flush = 1'b1;
                if (state_q == StRun) begin
                    state_d = StLuBubble;
                end
            end else begin
                // RUN, or LU_BUBBLE with the hazard masked for one cycle.
                state_d = StRun;
                if (branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (!imem_ready) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
                // A load-use cycle never issues mul/div: its operands are not valid yet.
                if (md_start) begin
                    state_d  = StMdBusy;
                    md_cnt_d = MdLoad;
                end
            end
        end
    end

    // Perf counters hold during a memory wait.
    assign stall_inc = rst_n & ~mem_wait & ~pc_en;

    // Controller state and mul/div occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    hz_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    hz_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MD_LAT=4, 4-bit counters).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MdLat = 4;
    localparam int unsigned CntW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_ex_hazard, branch_taken, md_start, imem_ready, dmem_req, dmem_ready;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic md_busy;
    logic [CntW-1:0] stall_cnt, flush_cnt;
    logic [4:0] act_en;
    logic [3:0] act_fl;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(
        .MD_LAT (MdLat),
        .CNT_W  (CntW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_ex_hazard (mem_ex_hazard),
        .branch_taken  (branch_taken),
        .md_start      (md_start),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .md_busy       (md_busy),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    assign act_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign act_fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    always #5 clk = ~clk;

    typedef struct packed {
        logic       h, b, m, ir, dq, dr;
        logic [4:0] en;     // {pc, ifid, idex, exmem, memwb}
        logic [3:0] fl;     // {ifid, idex, exmem, memwb}
        logic       busy;
        logic [7:0] stall;  // counter values seen before this row's edge
        logic [7:0] fcnt;
    } vec_t;

    function automatic vec_t mk(input logic h, b, m, ir, dq, dr, input logic [4:0] en,
                                input logic [3:0] fl, input logic busy,
                                input logic [7:0] stall, input logic [7:0] fcnt);
        vec_t v;
        v.h = h; v.b = b; v.m = m; v.ir = ir; v.dq = dq; v.dr = dr;
        v.en = en; v.fl = fl; v.busy = busy; v.stall = stall; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic h, b, m, ir, dq, dr);
        mem_ex_hazard = h;
        branch_taken  = b;
        md_start      = m;
        imem_ready    = ir;
        dmem_req      = dq;
        dmem_ready    = dr;
    endtask

    // Apply inputs at the negedge, check controls 1 unit later, advance one cycle.
    task automatic step(input string nm, input logic h, b, m, ir, dq, dr,
                        input logic [4:0] en, input logic [3:0] fl, input logic busy);
        drive(h, b, m, ir, dq, dr);
        #1;
        chk({nm, " en"}, 32'(act_en), 32'(en));
        chk({nm, " flush"}, 32'(act_fl), 32'(fl));
        chk({nm, " md_busy"}, 32'(md_busy), 32'(busy));
        @(negedge clk);
    endtask

    vec_t tbl[15];

    initial begin
        //           h  b  m  ir dq dr  en        fl       bsy stall fcnt
        tbl[0]  = mk(0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 0, 0, 0); // idle
        tbl[1]  = mk(1, 0, 0, 1, 0, 0, 5'b00011, 4'b0010, 0, 0, 0); // load-use
        tbl[2]  = mk(1, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 0, 1, 0); // masked
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 0, 1, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 4'b1100, 0, 1, 0); // branch beats imem
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 5'b00111, 4'b0100, 0, 1, 1); // imem stall
        tbl[6]  = mk(1, 1, 1, 1, 1, 0, 5'b00000, 4'b0000, 0, 2, 1); // mem wait wins
        tbl[7]  = mk(1, 0, 0, 1, 1, 1, 5'b00011, 4'b0010, 0, 2, 1); // mem done, load-use
        tbl[8]  = mk(1, 1, 0, 1, 0, 0, 5'b11111, 4'b1100, 0, 3, 1); // masked, branch
        tbl[9]  = mk(0, 0, 1, 1, 0, 0, 5'b11111, 4'b0000, 0, 3, 2); // md issue
        tbl[10] = mk(1, 1, 1, 1, 0, 0, 5'b00011, 4'b0010, 1, 3, 2); // MD busy x4
        tbl[11] = mk(1, 0, 0, 1, 0, 0, 5'b00011, 4'b0010, 1, 4, 2);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 5'b00011, 4'b0010, 1, 5, 2);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 5'b00011, 4'b0010, 1, 6, 2);
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 0, 7, 2); // back in RUN

        rst_n = 1'b0;
        drive(0, 0, 0, 1, 0, 0);
        #1;
        chk("reset en", 32'(act_en), 32'h0);
        chk("reset flush", 32'(act_fl), 32'hF);
        chk("reset md_busy", 32'(md_busy), 32'h0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset flush_cnt", 32'(flush_cnt), 32'h0);
        repeat (3) @(negedge clk);
        chk("reset held en", 32'(act_en), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].stall));
            chk($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].fcnt));
            step($sformatf("row%0d", i), tbl[i].h, tbl[i].b, tbl[i].m, tbl[i].ir,
                 tbl[i].dq, tbl[i].dr, tbl[i].en, tbl[i].fl, tbl[i].busy);
        end

        // Memory wait during mul/div: pipe frozen, unit still ends on schedule.
        step("md2 issue", 0, 0, 1, 1, 0, 0, 5'b11111, 4'b0000, 1'b0);
        step("md2 wait0", 0, 0, 0, 1, 1, 0, 5'b00000, 4'b0000, 1'b1);
        step("md2 wait1", 0, 0, 0, 1, 1, 0, 5'b00000, 4'b0000, 1'b1);
        step("md2 wait2", 0, 0, 0, 1, 1, 0, 5'b00000, 4'b0000, 1'b1);
        step("md2 last", 0, 0, 0, 1, 0, 0, 5'b00011, 4'b0010, 1'b1);
        step("md2 done", 0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 1'b0);
        chk("md2 stall_cnt", 32'(stall_cnt), 32'd8);
        chk("md2 flush_cnt", 32'(flush_cnt), 32'd2);

        // Counter saturation.
        drive(0, 0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("stall_cnt saturate", 32'(stall_cnt), 32'hF);
        drive(0, 1, 0, 1, 0, 0);
        repeat (16) @(negedge clk);
        chk("flush_cnt saturate", 32'(flush_cnt), 32'hF);
        chk("stall_cnt no wrap", 32'(stall_cnt), 32'hF);

        // Asynchronous reset in the middle of a mul/div.
        step("md3 issue", 0, 0, 1, 1, 0, 0, 5'b11111, 4'b0000, 1'b0);
        step("md3 busy", 0, 0, 0, 1, 0, 0, 5'b00011, 4'b0010, 1'b1);
        chk("md3 still busy", 32'(md_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst md_busy", 32'(md_busy), 32'h0);
        chk("async rst en", 32'(act_en), 32'h0);
        chk("async rst flush", 32'(act_fl), 32'hF);
        chk("async rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("async rst flush_cnt", 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post rst", 0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 1'b0);
        step("post rst2", 0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000, 1'b0);
        chk("post rst stall_cnt", 32'(stall_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
